// File: rtl/irq_ctrl_if.sv
// Request/offer bundle between the interrupt controller and the pipeline.
// The slave modport is the controller side; master is the cpu/source side.
interface irq_ctrl_if #(
    parameter int unsigned N_IRQ = 3,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned WIDTH = 32
);
    logic [N_IRQ-1:0] irq;
    logic             ie;
    logic             take;
    logic             eret;
    logic             int_req;
    logic [ID_W-1:0]  int_id;
    logic [WIDTH-1:0] int_vec;
    logic [N_IRQ-1:0] irw;
    logic [N_IRQ-1:0] in_service;

    modport slave (
        input  irq, ie, take, eret,
        output int_req, int_id, int_vec, irw, in_service
    );

    modport master (
        output irq, ie, take, eret,
        input  int_req, int_id, int_vec, irw, in_service
    );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-capturing, fixed-priority nesting interrupt controller: one offered
// request with its handler vector, in-service tracking via take/eret.
module irq_ctrl #(
    parameter int unsigned       N_IRQ      = 3,
    parameter int unsigned       ID_W       = 2,
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  VEC_BASE   = 32'h0000_1000,
    parameter int unsigned       VEC_STRIDE = 4
) (
    input  logic           clk,
    input  logic           rst,
    irq_ctrl_if.slave      bus
);
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] in_svc;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] grant;
    logic [N_IRQ-1:0] top;
    logic [ID_W-1:0]  cur;
    logic [ID_W-1:0]  sel;
    logic             busy;
    logic             any;
    logic             req;

    assign rise = bus.irq & ~irq_q;
    assign busy = |in_svc;

    always_comb begin
        cur = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (in_svc[i]) cur = ID_W'(i);
        end
    end

    // Strict nesting: only sources above the current in-service level compete.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            eligible[i] = pending[i] & (~busy | (ID_W'(i) > cur));
        end
    end

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (eligible[i]) sel = ID_W'(i);
        end
    end

    assign any = |eligible;
    assign req = bus.ie & any;

    always_comb begin
        grant = '0;
        if (bus.take && req) grant[sel] = 1'b1;
        top = '0;
        if (bus.eret && busy) top[cur] = 1'b1;
    end

    assign bus.int_req    = req;
    assign bus.int_id     = req ? sel : '0;
    assign bus.int_vec    = req ? (VEC_BASE + WIDTH'(sel) * WIDTH'(VEC_STRIDE)) : '0;
    assign bus.irw        = pending;
    assign bus.in_service = in_svc;

    // A fresh edge on the granted source re-arms it because rise is OR-ed after the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
            in_svc  <= '0;
        end else begin
            irq_q   <= bus.irq;
            pending <= (pending & ~grant) | rise;
            in_svc  <= (in_svc & ~top) | grant;
        end
    end
endmodule
